// File: rtl/sim_host_pkg.sv
// Shared types for the simulation host bridge: dispatch FSM encoding and entry field layouts.
package sim_host_pkg;

    localparam int unsigned FIELD_W = 32;
    localparam int unsigned HDR_W   = 3 * FIELD_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } dispatch_state_t;

    typedef struct packed {
        logic [FIELD_W-1:0] command;
        logic [FIELD_W-1:0] address;
        logic [FIELD_W-1:0] data;
    } cmd_hdr_t;

    typedef struct packed {
        logic [FIELD_W-1:0] status;
        logic [FIELD_W-1:0] address;
        logic [FIELD_W-1:0] data;
    } rsp_hdr_t;

endpackage

// File: rtl/sim_bridge_fifo.sv
// Synchronous FIFO with wrap-bit pointers; flush empties it and overrides push/pop.
module sim_bridge_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = IW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    assign dout = mem[rd_ptr[IW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[IW-1:0]] <= din;
    end

endmodule

// File: rtl/sim_host_bridge.sv
// Bridges sim-side commands to a master and master responses back to the sim, via two FIFOs.
// Optional per-pulse statistics counters are enabled with SIM_HOST_BRIDGE_STATS_EN.
module sim_host_bridge
    import sim_host_pkg::*;
#(
    parameter int unsigned CMD_DEPTH   = 4,
    parameter int unsigned RSP_DEPTH   = 4,
    parameter int unsigned COUNT_WIDTH = 28
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   i_sim_in_reset,
    output logic                   o_ih_reset,

    input  logic                   i_sim_in_ready,
    output logic                   o_sim_master_ready,
    input  logic [31:0]            i_sim_in_command,
    input  logic [31:0]            i_sim_in_address,
    input  logic [31:0]            i_sim_in_data,
    input  logic [COUNT_WIDTH-1:0] i_sim_in_data_count,

    input  logic                   i_master_ready,
    output logic                   o_ih_ready,
    output logic [31:0]            o_in_command,
    output logic [31:0]            o_in_address,
    output logic [31:0]            o_in_data,
    output logic [COUNT_WIDTH-1:0] o_in_data_count,

    input  logic                   i_oh_en,
    output logic                   o_oh_ready,
    input  logic [31:0]            i_out_status,
    input  logic [31:0]            i_out_address,
    input  logic [31:0]            i_out_data,
    input  logic [COUNT_WIDTH-1:0] i_out_data_count,

    input  logic                   i_sim_out_ready,
    output logic                   o_sim_out_en,
    output logic [31:0]            o_sim_out_status,
    output logic [31:0]            o_sim_out_address,
    output logic [31:0]            o_sim_out_data,
    output logic [COUNT_WIDTH-1:0] o_sim_out_data_count,

`ifdef SIM_HOST_BRIDGE_STATS_EN
    output logic [31:0]            o_cmd_issued,
    output logic [31:0]            o_rsp_delivered,
`endif
    output logic                   o_overflow
);

    localparam int unsigned ENTRY_W = HDR_W + COUNT_WIDTH;

    dispatch_state_t  state_q;
    dispatch_state_t  state_d;

    cmd_hdr_t         cmd_in_hdr;
    cmd_hdr_t         cmd_head_hdr;
    rsp_hdr_t         rsp_in_hdr;
    rsp_hdr_t         rsp_head_hdr;
    logic [ENTRY_W-1:0] cmd_din;
    logic [ENTRY_W-1:0] cmd_head;
    logic [ENTRY_W-1:0] rsp_din;
    logic [ENTRY_W-1:0] rsp_head;

    logic             cmd_full;
    logic             cmd_empty;
    logic             cmd_pop;
    logic             rsp_full;
    logic             rsp_empty;
    logic             rsp_pop;
    logic             cmd_drop;
    logic             rsp_drop;

    assign o_ih_reset         = i_sim_in_reset;
    assign o_sim_master_ready = !cmd_full;
    assign o_oh_ready         = !rsp_full;

    assign cmd_in_hdr = '{command: i_sim_in_command, address: i_sim_in_address, data: i_sim_in_data};
    assign rsp_in_hdr = '{status: i_out_status, address: i_out_address, data: i_out_data};
    assign cmd_din    = {cmd_in_hdr, i_sim_in_data_count};
    assign rsp_din    = {rsp_in_hdr, i_out_data_count};
    assign cmd_head_hdr = cmd_hdr_t'(cmd_head[ENTRY_W-1 -: HDR_W]);
    assign rsp_head_hdr = rsp_hdr_t'(rsp_head[ENTRY_W-1 -: HDR_W]);

    sim_bridge_fifo #(.WIDTH(ENTRY_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (i_sim_in_reset),
        .push  (i_sim_in_ready),
        .din   (cmd_din),
        .pop   (cmd_pop),
        .dout  (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty)
    );

    sim_bridge_fifo #(.WIDTH(ENTRY_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (i_sim_in_reset),
        .push  (i_oh_en),
        .din   (rsp_din),
        .pop   (rsp_pop),
        .dout  (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty)
    );

    // Dropped pushes: FIFO full with no pop freeing a slot this cycle.
    assign cmd_drop = i_sim_in_ready && cmd_full && !cmd_pop && !i_sim_in_reset;
    assign rsp_drop = i_oh_en && rsp_full && !rsp_pop && !i_sim_in_reset;

    // Response side pops at most every other cycle, gated by the outgoing strobe.
    assign rsp_pop = !rsp_empty && i_sim_out_ready && !o_sim_out_en && !i_sim_in_reset;

    // Dispatch next-state: pop happens on the IDLE->ISSUE transition.
    always_comb begin
        state_d = state_q;
        cmd_pop = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!cmd_empty && i_master_ready) begin
                    cmd_pop = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_GAP;
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (i_sim_in_reset) begin
            state_d = ST_IDLE;
            cmd_pop = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            o_ih_ready      <= 1'b0;
            o_in_command    <= '0;
            o_in_address    <= '0;
            o_in_data       <= '0;
            o_in_data_count <= '0;
        end else begin
            state_q    <= state_d;
            o_ih_ready <= cmd_pop;
            if (cmd_pop) begin
                o_in_command    <= cmd_head_hdr.command;
                o_in_address    <= cmd_head_hdr.address;
                o_in_data       <= cmd_head_hdr.data;
                o_in_data_count <= cmd_head[COUNT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_sim_out_en         <= 1'b0;
            o_sim_out_status     <= '0;
            o_sim_out_address    <= '0;
            o_sim_out_data       <= '0;
            o_sim_out_data_count <= '0;
        end else begin
            o_sim_out_en <= rsp_pop;
            if (rsp_pop) begin
                o_sim_out_status     <= rsp_head_hdr.status;
                o_sim_out_address    <= rsp_head_hdr.address;
                o_sim_out_data       <= rsp_head_hdr.data;
                o_sim_out_data_count <= rsp_head[COUNT_WIDTH-1:0];
            end
        end
    end

    // Sticky overflow, cleared only by a reset or sim-side flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_overflow <= 1'b0;
        end else if (i_sim_in_reset) begin
            o_overflow <= 1'b0;
        end else if (cmd_drop || rsp_drop) begin
            o_overflow <= 1'b1;
        end
    end

`ifdef SIM_HOST_BRIDGE_STATS_EN
    // Counters step on the same edge that raises each strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_cmd_issued    <= '0;
            o_rsp_delivered <= '0;
        end else if (i_sim_in_reset) begin
            o_cmd_issued    <= '0;
            o_rsp_delivered <= '0;
        end else begin
            if (cmd_pop) o_cmd_issued    <= o_cmd_issued + 32'd1;
            if (rsp_pop) o_rsp_delivered <= o_rsp_delivered + 32'd1;
        end
    end
`endif

endmodule

// File: doc/sim_host_bridge.md
SIM_HOST_BRIDGE -- requirements
Module: sim_host_bridge

Interface
REQ-001 SHALL have parameter CMD_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter RSP_DEPTH, default 4, response FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter COUNT_WIDTH, default 28, data-count field width.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 i_sim_in_reset  in  1  sim-side flush request; o_ih_reset  out  1  copy of i_sim_in_reset.
REQ-007 i_sim_in_ready  in  1  command push strobe; o_sim_master_ready  out  1  command FIFO not full.
REQ-008 i_sim_in_command/address/data  in  32 each; i_sim_in_data_count  in  COUNT_WIDTH; command entry fields.
REQ-009 i_master_ready  in  1  master accepts a command; o_ih_ready  out  1  one-cycle command strobe.
REQ-010 o_in_command/address/data  out  32 each; o_in_data_count  out  COUNT_WIDTH; registered command fields.
REQ-011 i_oh_en  in  1  response strobe; o_oh_ready  out  1  response FIFO not full.
REQ-012 i_out_status/address/data  in  32 each; i_out_data_count  in  COUNT_WIDTH; response fields.
REQ-013 i_sim_out_ready  in  1  sim accepts a response; o_sim_out_en  out  1  one-cycle response strobe.
REQ-014 o_sim_out_status/address/data  out  32 each; o_sim_out_data_count  out  COUNT_WIDTH; registered response fields.
REQ-015 o_overflow  out  1  sticky: push attempted into a full FIFO.

Function
REQ-016 Command push: i_sim_in_ready && o_sim_master_ready writes one entry {command,address,data,count}.
REQ-017 Dispatch FSM SHALL have states IDLE, ISSUE, GAP.
REQ-018 IDLE->ISSUE when command FIFO non-empty and i_master_ready=1; the head entry is popped and registered onto o_in_* that cycle.
REQ-019 ISSUE: o_ih_ready=1 for exactly one cycle, o_in_* stable; always ->GAP next cycle.
REQ-020 GAP: one idle cycle, o_in_* held; ->IDLE; minimum spacing between o_ih_ready pulses is 3 cycles.
REQ-021 o_in_* SHALL hold the last issued values until the next ISSUE.
REQ-022 Response push: i_oh_en && o_oh_ready writes one entry; i_oh_en while full is dropped and sets o_overflow.
REQ-023 Response pop: FIFO non-empty, i_sim_out_ready=1 and o_sim_out_en=0 in the current cycle -> next cycle o_sim_out_en=1 for one cycle with o_sim_out_* = head entry; max one response every 2 cycles.
REQ-024 Command push while full is dropped, sets o_overflow; FIFO contents unchanged.
REQ-025 Simultaneous push and pop on a full FIFO SHALL succeed (pop frees the slot same cycle); simultaneous push and pop on empty FIFO: push only.
REQ-026 FIFO pointers are log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full = MSBs differ, rest equal.
REQ-027 i_sim_in_reset=1 SHALL, synchronously, empty both FIFOs, force FSM to IDLE, deassert o_ih_ready and o_sim_out_en, clear o_overflow; o_in_*/o_sim_out_* retain values.
REQ-028 Strobes arriving in the same cycle as i_sim_in_reset are discarded.

Reset
REQ-029 rst low SHALL asynchronously set: FSM IDLE, FIFOs empty, o_ih_ready=0, o_sim_out_en=0, o_overflow=0, o_in_* = 0, o_sim_out_* = 0; hence o_sim_master_ready=1, o_oh_ready=1.
REQ-030 Reset asserted mid-ISSUE SHALL abort the strobe immediately; no partial command is replayed after release.

Configuration
REQ-031 Macro SIM_HOST_BRIDGE_STATS_EN defined: adds outputs o_cmd_issued and o_rsp_delivered (32 bits each), incremented per o_ih_ready / o_sim_out_en pulse, wrapping at 2^32, cleared by rst and i_sim_in_reset.
REQ-032 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-033 Shared package sim_host_pkg SHALL hold the FSM state encoding (IDLE=0, ISSUE=1, GAP=2) and the command/response entry field widths.
REQ-034 One sub-module sim_bridge_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/flush), instantiated twice: command width 96+COUNT_WIDTH, response width 96+COUNT_WIDTH.

Verification
REQ-035 Push cmd 0x1, addr 0x10, data 0xA5, count 1 with i_master_ready=1 -> o_ih_ready pulse 2 cycles after push, o_in_* match exactly.
REQ-036 i_master_ready=0, push 5 commands at CMD_DEPTH=4 -> o_sim_master_ready=0 after 4th, 5th dropped, o_overflow=1; raise i_master_ready -> exactly 4 pulses, in order, 3 cycles apart.
REQ-037 Pulse i_oh_en 3 times with status 0x1,0x2,0x3 while i_sim_out_ready=0 -> no o_sim_out_en; raise ready -> 3 strobes in order, 2 cycles apart.
REQ-038 Full response FIFO, i_oh_en coincident with a pop -> entry accepted, o_overflow stays 0.
REQ-039 Assert i_sim_in_reset with 2 queued commands and 1 response -> both FIFOs empty, no further strobes, o_overflow=0, o_ih_reset follows input.
REQ-040 Drop rst during ISSUE -> o_ih_ready=0 same cycle (asynchronous), all outputs at REQ-029 values; with SIM_HOST_BRIDGE_STATS_EN, counters read 0.
